// File: rtl/steer_pkg.sv
// steer_pkg: steering codes, command bytes and sequencer states shared with the PWM stage.
package steer_pkg;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_MID   = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [7:0] CMD_L = 8'h4C;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_C = 8'h43;
    typedef enum logic [1:0] {S_MID, S_LEFT, S_RIGHT, S_CENTER} state_t;
    function automatic logic [1:0] dir_of(state_t s);
        return s == S_LEFT ? DIR_LEFT : s == S_RIGHT ? DIR_RIGHT : DIR_MID;
    endfunction
endpackage

// File: rtl/steer_cmd_if.sv
// steer_cmd_if: receiver byte strobe in, steering code and link status out.
interface steer_cmd_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [1:0] direc;
    logic       link_ok;
    logic       cmd_err;
    modport master (output rx_valid, rx_data, input direc, link_ok, cmd_err);
    modport slave  (input rx_valid, rx_data, output direc, link_ok, cmd_err);
endinterface

// File: rtl/steer_wdog.sv
// steer_wdog: saturating link watchdog; expire pulses on the cycle the count reaches TIMEOUT.
module steer_wdog #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk_dec,
    input  logic rst_n,
    input  logic clr,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = clr ? '0 : cnt_q == CW'(TIMEOUT) ? cnt_q : cnt_q + 1'b1;
    end
    assign expire = !clr && cnt_q == CW'(TIMEOUT - 1);
    always_ff @(posedge clk_dec or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/steer_cmd.sv
// steer_cmd: decodes remote command bytes into a steering code, forcing a timed mid pass on reversals.
module steer_cmd
    import steer_pkg::*;
#(
    parameter int MID_HOLD = 80,
    parameter int TIMEOUT  = 1000
) (
    input logic        clk_dec,
    input logic        rst_n,
    steer_cmd_if.slave bus
);
    localparam int HW = $clog2(MID_HOLD + 1);
    state_t        state_q, state_d, pend_q, pend_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [1:0]    direc_q, direc_d;
    logic          link_q, link_d, err_q, err_d;
    logic          is_l, is_r, is_c, is_cmd, expire;
    assign is_l   = bus.rx_valid && bus.rx_data == CMD_L;
    assign is_r   = bus.rx_valid && bus.rx_data == CMD_R;
    assign is_c   = bus.rx_valid && bus.rx_data == CMD_C;
    assign is_cmd = is_l || is_r || is_c;
    steer_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk_dec(clk_dec),
        .rst_n  (rst_n),
        .clr    (is_cmd),
        .expire (expire)
    );
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        case (state_q)
            S_LEFT: begin
                state_d = is_r ? S_CENTER : is_c ? S_MID : S_LEFT;
                pend_d  = S_RIGHT;
            end
            S_RIGHT: begin
                state_d = is_l ? S_CENTER : is_c ? S_MID : S_RIGHT;
                pend_d  = S_LEFT;
            end
            S_CENTER: begin
                pend_d  = is_l ? S_LEFT : is_r ? S_RIGHT : pend_q;
                state_d = is_c ? S_MID : hold_q == HW'(1) ? pend_d : S_CENTER;
            end
            default: state_d = is_l ? S_LEFT : is_r ? S_RIGHT : S_MID;
        endcase
        if (expire) state_d = S_MID;
        // the hold loads only on entry; exit happens as it steps from 1 to 0
        hold_d  = state_d != S_CENTER ? '0 : state_q == S_CENTER ? hold_q - 1'b1 : HW'(MID_HOLD);
        direc_d = dir_of(state_d);
        link_d  = is_cmd ? 1'b1 : expire ? 1'b0 : link_q;
        err_d   = bus.rx_valid && !is_cmd;
    end
    always_ff @(posedge clk_dec or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_MID;
            pend_q  <= S_MID;
            hold_q  <= '0;
            direc_q <= DIR_MID;
            link_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            hold_q  <= hold_d;
            direc_q <= direc_d;
            link_q  <= link_d;
            err_q   <= err_d;
        end
    end
    assign bus.direc   = direc_q;
    assign bus.link_ok = link_q;
    assign bus.cmd_err = err_q;
endmodule

// File: tb/tb_steer_cmd.sv
// tb_steer_cmd: directed and randomized checks of steer_cmd against a timeline-based reference model.
module tb_steer_cmd;
    localparam int MID_HOLD = 80;
    localparam int TIMEOUT  = 1000;
    localparam int MM = 0, ML = 1, MR = 2, MC = 3;
    logic clk_dec = 1'b0;
    logic rst_n   = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   t, m_mode, m_pend, m_exit, m_last;
    logic m_link, m_err;
    steer_cmd_if bus ();
    steer_cmd #(.MID_HOLD(MID_HOLD), .TIMEOUT(TIMEOUT)) dut (
        .clk_dec(clk_dec),
        .rst_n  (rst_n),
        .bus    (bus)
    );
    always #5 clk_dec = ~clk_dec;
    function automatic logic [1:0] m_dir();
        return m_mode == ML ? 2'b10 : m_mode == MR ? 2'b01 : 2'b00;
    endfunction
    task automatic model_reset();
        t = 0; m_mode = MM; m_pend = MM; m_exit = -1; m_last = -1;
        m_link = 1'b0; m_err = 1'b0;
    endtask
    // Reversal completes at an absolute cycle; link expiry is TIMEOUT cycles after the last command.
    task automatic model(input logic v, input logic [7:0] d);
        bit l, r, c, cmd;
        l = v && d == 8'h4C; r = v && d == 8'h52; c = v && d == 8'h43; cmd = l || r || c;
        m_err = v && !cmd;
        case (m_mode)
            MM: m_mode = l ? ML : r ? MR : MM;
            ML: if (r) begin m_mode = MC; m_pend = MR; m_exit = t + MID_HOLD + 1; end
                else if (c) m_mode = MM;
            MR: if (l) begin m_mode = MC; m_pend = ML; m_exit = t + MID_HOLD + 1; end
                else if (c) m_mode = MM;
            default: if (c) m_mode = MM;
                else begin
                    if (l) m_pend = ML;
                    if (r) m_pend = MR;
                    if (t + 1 == m_exit) m_mode = m_pend;
                end
        endcase
        if (cmd) begin m_last = t; m_link = 1'b1; end
        else if (t == m_last + TIMEOUT) begin m_mode = MM; m_link = 1'b0; end
        t++;
    endtask
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, t);
        end
    endtask
    task automatic step(input logic v, input logic [7:0] d);
        bus.rx_valid = v;
        bus.rx_data  = d;
        @(posedge clk_dec);
        model(v, d);
        @(negedge clk_dec);
        vectors++;
        if (bus.direc !== m_dir() || bus.link_ok !== m_link || bus.cmd_err !== m_err) begin
            miscompares++;
            $display("FAIL cycle %0d: direc=%b link_ok=%b cmd_err=%b, expected %b %b %b",
                     t, bus.direc, bus.link_ok, bus.cmd_err, m_dir(), m_link, m_err);
        end
    endtask
    initial begin
        logic       v;
        logic [7:0] d;
        int         kind, len;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #3;
        chk("reset_direc", 8'(bus.direc), 8'h00);
        chk("reset_link", 8'(bus.link_ok), 8'h00);
        chk("reset_err", 8'(bus.cmd_err), 8'h00);
        @(negedge clk_dec);
        @(negedge clk_dec);
        rst_n = 1'b1;
        model_reset();
        step(0, 8'h00);
        step(1, 8'h4C);
        chk("L_direc", 8'(bus.direc), 8'h02);
        chk("L_link", 8'(bus.link_ok), 8'h01);
        chk("L_err", 8'(bus.cmd_err), 8'h00);
        step(1, 8'h52);
        for (int k = 1; k <= MID_HOLD; k++) begin
            chk("rev_hold", 8'(bus.direc), 8'h00);
            step(0, 8'h00);
        end
        chk("rev_exit", 8'(bus.direc), 8'h01);
        step(1, 8'h4C);
        for (int k = 0; k < 40; k++) step(0, 8'h00);
        step(1, 8'h43);
        for (int k = 0; k < 50; k++) begin
            chk("abort_mid", 8'(bus.direc), 8'h00);
            step(0, 8'h00);
        end
        step(1, 8'h4C);
        chk("after_abort_L", 8'(bus.direc), 8'h02);
        step(1, 8'h43);
        step(1, 8'h52);
        chk("R_direc", 8'(bus.direc), 8'h01);
        for (int i = 1; i < TIMEOUT; i++) begin
            step(i == 400, 8'h41);
            if (i == 400) begin
                chk("err_pulse", 8'(bus.cmd_err), 8'h01);
                chk("err_direc", 8'(bus.direc), 8'h01);
            end
            if (i == 401) chk("err_clear", 8'(bus.cmd_err), 8'h00);
        end
        chk("pre_expiry_direc", 8'(bus.direc), 8'h01);
        chk("pre_expiry_link", 8'(bus.link_ok), 8'h01);
        step(0, 8'h00);
        chk("expiry_direc", 8'(bus.direc), 8'h00);
        chk("expiry_link", 8'(bus.link_ok), 8'h00);
        step(1, 8'h52);
        chk("relink_direc", 8'(bus.direc), 8'h01);
        chk("relink_link", 8'(bus.link_ok), 8'h01);
        for (int i = 1; i < TIMEOUT; i++) step(0, 8'h00);
        step(1, 8'h52);
        chk("race_direc", 8'(bus.direc), 8'h01);
        chk("race_link", 8'(bus.link_ok), 8'h01);
        for (int i = 0; i < 3; i++) step(0, 8'h00);
        step(1, 8'h4C);
        for (int i = 0; i < 10; i++) step(0, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_direc", 8'(bus.direc), 8'h00);
        chk("async_rst_link", 8'(bus.link_ok), 8'h00);
        @(posedge clk_dec);
        @(posedge clk_dec);
        @(negedge clk_dec);
        rst_n = 1'b1;
        model_reset();
        step(1, 8'h52);
        chk("post_rst_R", 8'(bus.direc), 8'h01);
        for (int s = 0; s < 60; s++) begin
            kind = $urandom_range(0, 3);
            len  = kind == 3 ? TIMEOUT + 100 : $urandom_range(50, 400);
            for (int i = 0; i < len; i++) begin
                v = kind == 3 ? 1'b0 : kind == 2 ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 3) == 0);
                case ($urandom_range(0, 3))
                    0: d = 8'h4C;
                    1: d = 8'h52;
                    2: d = 8'h43;
                    default: d = 8'($urandom);
                endcase
                step(v, d);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/steer_cmd.md
# steer_cmd

Command decoder and safety sequencer that turns remote-control bytes into the 2-bit steering code consumed by the servo PWM stage. It accepts one byte per `rx_valid` pulse from the receiver front-end and maps valid command characters to left, mid or right. It forces a timed pass through mid on any left↔right reversal, and returns steering to mid when the link goes silent. Its `direc` output wires directly to the steering PWM generator's `direc` input.

## Interface
- `MID_HOLD`, 80: clk_dec cycles `direc` must stay mid during a left↔right reversal (2 servo frames of 40).
- `TIMEOUT`, 1000: clk_dec cycles without a valid command before fail-safe to mid.
- `clk_dec`  in  1  block clock, shared with the servo PWM stage; one clock domain, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid this cycle.
- `rx_data`  in  8  received byte.
- `direc`  out  2  steering code: left 2'b10, mid 2'b00, right 2'b01; 2'b11 never driven.
- `link_ok`  out  1  high while the watchdog has not expired since the last valid command.
- `cmd_err`  out  1  one-cycle pulse for each byte that is not a command.

## Operation
- Command bytes: 'L' 0x4C → left, 'R' 0x52 → right, 'C' 0x43 → mid. Any other byte is an error: pulse `cmd_err`, leave state unchanged, do not refresh the watchdog.
- FSM states: MID, LEFT, RIGHT, CENTER. `direc` is registered from the state: MID and CENTER give 2'b00, LEFT gives 2'b10, RIGHT gives 2'b01.
- MID: 'L' goes to LEFT, 'R' goes to RIGHT, 'C' stays.
- LEFT: 'R' goes to CENTER with pending = RIGHT and the hold counter loaded with MID_HOLD. 'C' goes to MID. 'L' stays.
- RIGHT: mirror of LEFT.
- CENTER: hold counter decrements every cycle. On the cycle it reaches 0, go to pending. 'C' aborts to MID. 'L' or 'R' overwrites pending; the hold counter is not reloaded.
- Watchdog: cycle counter cleared by every valid command, saturates at TIMEOUT. On reaching TIMEOUT:
  - state forced to MID, CENTER aborted;
  - `link_ok` cleared.
- A valid command sets `link_ok` to 1.
- Counter widths are `$clog2(param+1)`. No wrap: the hold counter stops at 0 and the watchdog saturates.

## Timing
- Reset values: `direc` = 2'b00, `link_ok` = 0, `cmd_err` = 0, state MID, both counters 0.
- Command latency: byte at cycle T appears on `direc` and `link_ok` at T+1. `cmd_err` is high during T+1 only.
- Reversal: 'R' at T while in LEFT gives `direc` = 00 from T+1 through T+MID_HOLD, then 01 at T+MID_HOLD+1.
- Timeout: last valid command at T; `direc` = 00 and `link_ok` = 0 at T+TIMEOUT+1.
- Simultaneous events:
  - valid command in the same cycle as watchdog expiry: the command wins, and the watchdog clears.
  - command in the same cycle the hold reaches 0: 'C' wins and gives MID; 'L'/'R' sets pending and the exit uses the new pending.
- Reset mid-operation: everything returns to reset values asynchronously, with no hold sequence.

## Structure
- Shared package `steer_pkg`:
  - direc codes `DIR_LEFT`, `DIR_MID`, `DIR_RIGHT`;
  - command bytes `CMD_L`, `CMD_R`, `CMD_C`;
  - state enum.
  The PWM stage uses the same direc codes.
- One sub-module: `steer_wdog`, a saturating watchdog counter with clear and expired outputs, parameterised by TIMEOUT. FSM and hold counter stay in the top level.

## Test plan
- Reset, then 'L' at T → `direc` = 10 and `link_ok` = 1 at T+1; `cmd_err` stays 0.
- In LEFT, send 'R' at T → `direc` = 00 for cycles T+1..T+80, then 01 at T+81.
- In CENTER, send 'C' at hold count 40 → `direc` stays 00 and the state is MID. A later 'L' gives 10 on the next cycle.
- Send byte 0x41 → `cmd_err` high for exactly 1 cycle, `direc` unchanged, and the watchdog is not refreshed: expiry still occurs 1000 cycles after the previous valid command.
- In RIGHT, send no bytes for 1000 cycles → `direc` = 00 and `link_ok` = 0. Then 'R' → 01 and `link_ok` = 1 next cycle. Also check 'R' landing on the exact expiry cycle → `direc` stays 01.
- Assert `rst_n` = 0 during CENTER → `direc` = 00 immediately with no clock edge. After release, 'R' → 01 at T+1 with no hold.
